axi_req_arbiter: RTL



---
 rtl/axi_req_arbiter_pkg.sv | 25 ++
 rtl/axi_req_arbiter_arb_pick.sv | 18 +
 rtl/axi_req_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/axi_req_arbiter_pkg.sv
// Shared encodings for the IF/MEM request arbiter in front of the AXI master.
// State, grant and default-ID definitions; no logic.
package axi_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_MEM  = 2'd2
    } gnt_t;

    localparam logic [3:0] DEF_IF_ID  = 4'd0;
    localparam logic [3:0] DEF_MEM_ID = 4'd1;

    // Request/grant vector bit positions and pointer encoding (last winner).
    localparam int   REQ_IF  = 0;
    localparam int   REQ_MEM = 1;
    localparam logic RR_IF   = 1'b0;

endpackage

// File: rtl/axi_req_arbiter_arb_pick.sv
// Combinational two-way picker: one-hot grant from requests and last-winner pointer.
// On a tie the requester that did not win last is chosen; a pointer pinned to IF gives MEM priority.
module arb_pick
    import axi_req_arbiter_pkg::*;
(
    input  logic [1:0] reqs,
    input  logic       pointer,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = reqs;
        if (reqs == 2'b11) begin
            gnt = (pointer == RR_IF) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/axi_req_arbiter.sv
// Arbitrates IF/MEM onto the AXI master cpu port (IDLE->REQ->DONE); ack at t+2+N for N stalled REQ cycles.
// Requests are held until ack; master stall holds REQ. Macro ARB_ROUND_ROBIN_EN selects round-robin ties.
module axi_req_arbiter
    import axi_req_arbiter_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [3:0] IF_ID  = DEF_IF_ID,
    parameter logic [3:0] MEM_ID = DEF_MEM_ID
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic              m_ce_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_we_o,
    output logic [3:0]        m_sel_o,
    output logic [3:0]        m_id_o,
    input  logic [DATA_W-1:0] m_data_i,
    input  logic              m_stallreq_i,
    output logic              busy_o
);

    arb_state_t        state_q, state_d;
    gnt_t              gnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [3:0]        id_q;
    logic              discard_q;
    logic [1:0]        reqs;
    logic [1:0]        pick;
    logic              rr_ptr;
    logic              grant;
    logic              done;

    // A flush in IDLE kills the IF request for that cycle only.
    assign reqs = {mem_req_i, if_req_i & ~if_flush_i};

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rr_q <= RR_IF;
        end else if (grant) begin
            rr_q <= pick[REQ_MEM];
        end
    end

    assign rr_ptr = rr_q;
`else
    assign rr_ptr = RR_IF;
`endif

    arb_pick u_pick (
        .reqs    (reqs),
        .pointer (rr_ptr),
        .gnt     (pick)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        done    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|reqs) begin
                    grant   = 1'b1;
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (!m_stallreq_i) begin
                    done    = 1'b1;
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            gnt_q     <= GNT_NONE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            wdata_q   <= '0;
            id_q      <= 4'h0;
            rdata_q   <= '0;
            discard_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    discard_q <= 1'b0;
                    if (grant && pick[REQ_MEM]) begin
                        gnt_q   <= GNT_MEM;
                        addr_q  <= mem_addr_i;
                        we_q    <= mem_we_i;
                        sel_q   <= mem_sel_i;
                        wdata_q <= mem_wdata_i;
                        id_q    <= MEM_ID;
                    end else if (grant && pick[REQ_IF]) begin
                        gnt_q   <= GNT_IF;
                        addr_q  <= if_addr_i;
                        we_q    <= 1'b0;
                        sel_q   <= 4'hF;
                        wdata_q <= '0;
                        id_q    <= IF_ID;
                    end
                end
                ARB_REQ: begin
                    // The AXI burst cannot be aborted, so a flush only suppresses the ack.
                    if (gnt_q == GNT_IF && if_flush_i) begin
                        discard_q <= 1'b1;
                    end
                    if (done) begin
                        rdata_q <= m_data_i;
                    end
                end
                ARB_DONE: gnt_q <= GNT_NONE;
                default:  gnt_q <= GNT_NONE;
            endcase
        end
    end

    assign m_ce_o      = (state_q == ARB_REQ);
    assign m_addr_o    = addr_q;
    assign m_data_o    = wdata_q;
    assign m_we_o      = we_q;
    assign m_sel_o     = sel_q;
    assign m_id_o      = id_q;
    assign busy_o      = (state_q != ARB_IDLE);
    assign if_rdata_o  = rdata_q;
    assign mem_rdata_o = rdata_q;
    assign if_ack_o    = (state_q == ARB_DONE) && (gnt_q == GNT_IF) && !discard_q;
    assign mem_ack_o   = (state_q == ARB_DONE) && (gnt_q == GNT_MEM);

endmodule
